dwrr_pkt_sched: RTL and testbench

Deficit-weighted round-robin scheduler for variable-length, multi-beat packets sharing one output link. Each requester presents the length of its head packet in beats. The block keeps a deficit counter per requester, measured in beats. Once it selects a requester, it holds that requester's grant for the whole packet and counts beats against the downstream ready. It sits between the per-port packet queues and the shared link, and replaces the single-size-packet arbiter wherever packets span more than one beat.

---
 rtl/dwrr_pkt_sched_if.sv | 26 ++
 rtl/dwrr_pkt_sched.sv | 152 +++++++++++++++
 tb/tb_dwrr_pkt_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dwrr_pkt_sched_if.sv
// Request, length and quantum inputs plus per-beat grant outputs of the DWRR packet scheduler.
// The requester/link side uses the master modport; the scheduler uses the slave modport.
interface dwrr_pkt_sched_if #(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int LWID     = 4
);
    logic [NUM_REQS-1:0]      reqs;
    logic [NUM_REQS*LWID-1:0] req_len;
    logic [NUM_REQS*QWID-1:0] input_quantums;
    logic                     out_ready;
    logic [NUM_REQS-1:0]      gnt;
    logic                     beat_valid;
    logic                     sop;
    logic                     eop;

    modport master (
        output reqs, req_len, input_quantums, out_ready,
        input  gnt, beat_valid, sop, eop
    );

    modport slave (
        input  reqs, req_len, input_quantums, out_ready,
        output gnt, beat_valid, sop, eop
    );
endinterface

// File: rtl/dwrr_pkt_sched.sv
// Deficit-weighted round-robin scheduler for multi-beat packets on one shared output link.
// Optional DWRR_SKIP_EN: the round-robin pointer jumps straight to the next requesting index.
module dwrr_pkt_sched #(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int LWID     = 4,
    parameter int CNTWID   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input logic             clk,
    input logic             rst,
    dwrr_pkt_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, XFER} state_e;

    state_e            state_q, state_d;
    logic [CNTWID-1:0] rrPtr_q, rrPtr_d;
    logic              fresh_q, fresh_d;
    logic [QWID-1:0]   def_q [NUM_REQS];
    logic [QWID-1:0]   def_d [NUM_REQS];
    logic [LWID-1:0]   len_q, len_d;
    logic [LWID-1:0]   beatCnt_q, beatCnt_d;

    logic [LWID-1:0]     curLen;
    logic [LWID-1:0]     effLen;
    logic [QWID-1:0]     curQuantum;
    logic [QWID-1:0]     curDef;
    logic [QWID:0]       addSum;
    logic                lastBeat;
    logic [CNTWID-1:0]   nextPtr;
    logic [CNTWID-1:0]   advPtr;
    logic [NUM_REQS-1:0] skipClear;

    assign curLen     = bus.req_len[rrPtr_q*LWID +: LWID];
    assign effLen     = (curLen == '0) ? LWID'(1) : curLen;
    assign curQuantum = bus.input_quantums[rrPtr_q*QWID +: QWID];
    assign curDef     = def_q[rrPtr_q];
    assign addSum     = {1'b0, curDef} + {1'b0, curQuantum};
    assign lastBeat   = (beatCnt_q == len_q - 1'b1);
    assign nextPtr    = (rrPtr_q == CNTWID'(NUM_REQS-1)) ? '0 : rrPtr_q + 1'b1;

`ifdef DWRR_SKIP_EN
    int   idx;
    logic found;

    // Rotating search from cur+1; idle indices passed over lose their deficit, as a full visit would do.
    always_comb begin
        advPtr    = nextPtr;
        skipClear = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k < NUM_REQS; k++) begin
            idx = (int'(rrPtr_q) + k) % NUM_REQS;
            if (!found) begin
                if (bus.reqs[idx]) begin
                    found  = 1'b1;
                    advPtr = CNTWID'(idx);
                end else begin
                    skipClear[idx] = 1'b1;
                end
            end
        end
        if (!found) begin
            skipClear = '0;
        end
    end
`else
    assign advPtr    = nextPtr;
    assign skipClear = '0;
`endif

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        fresh_d   = fresh_q;
        len_d     = len_q;
        beatCnt_d = beatCnt_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            def_d[i] = def_q[i];
        end

        case (state_q)
            IDLE: begin
                if (|bus.reqs) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (fresh_q) begin
                    def_d[rrPtr_q] = addSum[QWID] ? '1 : addSum[QWID-1:0];
                    fresh_d        = 1'b0;
                end else if (bus.reqs[rrPtr_q] && (curDef >= QWID'(effLen))) begin
                    len_d     = effLen;
                    beatCnt_d = '0;
                    state_d   = XFER;
                end else begin
                    if (!bus.reqs[rrPtr_q]) begin
                        def_d[rrPtr_q] = '0;
                    end
                    for (int i = 0; i < NUM_REQS; i++) begin
                        if (skipClear[i]) begin
                            def_d[i] = '0;
                        end
                    end
                    rrPtr_d = advPtr;
                    fresh_d = 1'b1;
                    state_d = (|bus.reqs) ? EVAL : IDLE;
                end
            end
            XFER: begin
                // The packet is committed: only out_ready and the latched length matter here.
                if (bus.out_ready) begin
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (lastBeat) begin
                        def_d[rrPtr_q] = curDef - QWID'(len_q);
                        fresh_d        = 1'b0;
                        state_d        = EVAL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            fresh_q   <= 1'b1;
            len_q     <= '0;
            beatCnt_q <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                def_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            fresh_q   <= fresh_d;
            len_q     <= len_d;
            beatCnt_q <= beatCnt_d;
            for (int i = 0; i < NUM_REQS; i++) begin
                def_q[i] <= def_d[i];
            end
        end
    end

    assign bus.gnt        = (state_q == XFER) ? (NUM_REQS'(1) << rrPtr_q) : '0;
    assign bus.beat_valid = (state_q == XFER);
    assign bus.sop        = (state_q == XFER) && (beatCnt_q == '0);
    assign bus.eop        = (state_q == XFER) && lastBeat;
endmodule

// File: tb/tb_dwrr_pkt_sched.sv
// Directed bench for dwrr_pkt_sched: reset, weighting, deficit carry, stall, saturation, zero length.
// Idle-gap expectations differ between the default and the DWRR_SKIP_EN builds.
module tb_dwrr_pkt_sched;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

`ifdef DWRR_SKIP_EN
    localparam int SoloGap       = 5;
    localparam int CarryFirstGap = 6;
    localparam int RearmGap      = 8;
`else
    localparam int SoloGap       = 9;
    localparam int CarryFirstGap = 10;
    localparam int RearmGap      = 16;
`endif

    dwrr_pkt_sched_if #(.NUM_REQS(4), .QWID(8), .LWID(4)) bus ();

    dwrr_pkt_sched #(.NUM_REQS(4), .QWID(8), .LWID(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l,
                                 input logic [31:0] q, input logic rdy);
        bus.reqs           = r;
        bus.req_len        = l;
        bus.input_quantums = q;
        bus.out_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Counts idle samples until a grant appears, bounded so a stuck scheduler still ends the run.
    task automatic waitGrant(input string tag, input logic [3:0] expGnt, input int expGap);
        int gap;
        gap = 0;
        @(negedge clk);
        while (bus.gnt == 4'b0000 && gap < 64) begin
            gap++;
            @(negedge clk);
        end
        checkOutput({tag, " gnt"}, 32'(bus.gnt), 32'(expGnt));
        checkOutput({tag, " gap"}, 32'(gap), 32'(expGap));
    endtask

    task automatic runPacket(input string tag, input logic [3:0] expGnt, input int len,
                             input int expGap);
        waitGrant(tag, expGnt, expGap);
        for (int b = 0; b < len; b++) begin
            if (b > 0) begin
                @(negedge clk);
            end
            checkOutput({tag, " beat gnt"}, 32'(bus.gnt), 32'(expGnt));
            checkOutput({tag, " beat_valid"}, 32'(bus.beat_valid), 32'd1);
            checkOutput({tag, " sop"}, 32'(bus.sop), 32'(b == 0));
            checkOutput({tag, " eop"}, 32'(bus.eop), 32'(b == len - 1));
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " gnt"}, 32'(bus.gnt), 32'd0);
        checkOutput({tag, " beat_valid"}, 32'(bus.beat_valid), 32'd0);
        checkOutput({tag, " sop"}, 32'(bus.sop), 32'd0);
        checkOutput({tag, " eop"}, 32'(bus.eop), 32'd0);
    endtask

    task automatic stallStep(input string tag, input logic rdy, input logic expSop,
                             input logic expEop);
        bus.out_ready = rdy;
        @(negedge clk);
        checkOutput({tag, " gnt"}, 32'(bus.gnt), 32'd1);
        checkOutput({tag, " sop"}, 32'(bus.sop), 32'(expSop));
        checkOutput({tag, " eop"}, 32'(bus.eop), 32'(expEop));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(4'b1111, {4'd2, 4'd2, 4'd2, 4'd2}, {8'd2, 8'd2, 8'd4, 8'd2}, 1'b1);
        #2 rst = 1'b0;

        // Reset hold with all requesters active, then weighting 2/4/2/2 with length 2.
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset hold");
        rst = 1'b1;
        runPacket("w r0", 4'b0001, 2, 2);
        runPacket("w r1a", 4'b0010, 2, 3);
        runPacket("w r1b", 4'b0010, 2, 1);
        runPacket("w r2", 4'b0100, 2, 3);
        runPacket("w r3", 4'b1000, 2, 3);
        runPacket("w r0 again", 4'b0001, 2, 3);
        runPacket("w r1 again", 4'b0010, 2, 3);

        // Single requester, length 3, quantum 3.
        rst = 1'b0;
        applyStimulus(4'b0001, {4'd3, 4'd3, 4'd3, 4'd3}, {8'd3, 8'd3, 8'd3, 8'd3}, 1'b1);
        @(negedge clk);
        checkIdleOutputs("solo reset");
        rst = 1'b1;
        runPacket("solo p0", 4'b0001, 3, 2);
        runPacket("solo p1", 4'b0001, 3, SoloGap);
        runPacket("solo p2", 4'b0001, 3, SoloGap);

        // Stall: length 5, ready toggling; a length change mid-packet must be ignored.
        rst = 1'b0;
        applyStimulus(4'b0001, {4'd1, 4'd1, 4'd1, 4'd5}, {8'd1, 8'd1, 8'd1, 8'd5}, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        waitGrant("stall", 4'b0001, 2);
        checkOutput("stall first sop", 32'(bus.sop), 32'd1);
        checkOutput("stall first eop", 32'(bus.eop), 32'd0);
        bus.req_len = {4'd1, 4'd1, 4'd1, 4'd1};
        stallStep("stall b1", 1'b1, 1'b0, 1'b0);
        stallStep("stall hold1", 1'b0, 1'b0, 1'b0);
        stallStep("stall b2", 1'b1, 1'b0, 1'b0);
        stallStep("stall hold2", 1'b0, 1'b0, 1'b0);
        stallStep("stall b3", 1'b1, 1'b0, 1'b0);
        stallStep("stall b4", 1'b1, 1'b0, 1'b1);
        stallStep("stall hold4", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checkIdleOutputs("reset mid-packet");

        // Deficit carry: quantum 3, length 4; also shows deficits restart at 0 after reset.
        applyStimulus(4'b0001, {4'd1, 4'd1, 4'd1, 4'd4}, {8'd1, 8'd1, 8'd1, 8'd3}, 1'b1);
        @(negedge clk);
        checkIdleOutputs("carry reset");
        rst = 1'b1;
        runPacket("carry p0", 4'b0001, 4, CarryFirstGap);
        runPacket("carry p1", 4'b0001, 4, SoloGap);
        bus.reqs = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("carry drop gnt", 32'(bus.gnt), 32'd0);
        end
        bus.reqs = 4'b0001;
        runPacket("carry rearm", 4'b0001, 4, RearmGap);

        // Saturation: quantum 255, length 14 leaves remainder 3; the next add must clamp at 255.
        rst = 1'b0;
        applyStimulus(4'b0001, {4'd1, 4'd1, 4'd1, 4'd14}, {8'd1, 8'd1, 8'd1, 8'd255}, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        runPacket("sat first", 4'b0001, 14, 2);
        for (int p = 1; p < 18; p++) begin
            runPacket("sat run", 4'b0001, 14, 1);
        end
        runPacket("sat clamp", 4'b0001, 14, SoloGap);
        runPacket("sat clamp next", 4'b0001, 14, 1);

        // Zero length is a 1-beat packet.
        rst = 1'b0;
        applyStimulus(4'b0001, {4'd1, 4'd1, 4'd1, 4'd0}, {8'd1, 8'd1, 8'd1, 8'd2}, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        runPacket("zero p0", 4'b0001, 1, 2);
        runPacket("zero p1", 4'b0001, 1, 1);
        runPacket("zero p2", 4'b0001, 1, SoloGap);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
